// File: rtl/la_wb_master.sv
// la_wb_master: turns one toggle-signalled logic-analyzer command into a single
// Wishbone classic cycle with optional timeout and address auto-increment.
module la_wb_master #(
  parameter int unsigned ADR_W       = 32,
  parameter int unsigned DAT_W       = 32,
  parameter int unsigned TIMEOUT     = 255,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  // management side
  input  logic                 la_req_tgl,
  input  logic                 la_we,
  input  logic [DAT_W/8-1:0]   la_sel,
  input  logic [ADR_W-1:0]     la_adr,
  input  logic [DAT_W-1:0]     la_dat,
  input  logic                 la_adr_inc,
  output logic                 la_ack_tgl,
  output logic [DAT_W-1:0]     la_rdat,
  output logic                 la_err,
  output logic                 la_busy,
  output logic [15:0]          la_cnt,
  // Wishbone master
  output logic                 wbm_cyc_o,
  output logic                 wbm_stb_o,
  output logic                 wbm_we_o,
  output logic [DAT_W/8-1:0]   wbm_sel_o,
  output logic [ADR_W-1:0]     wbm_adr_o,
  output logic [DAT_W-1:0]     wbm_dat_o,
  input  logic [DAT_W-1:0]     wbm_dat_i,
  input  logic                 wbm_ack_i
);

  localparam int unsigned SEL_W = DAT_W / 8;
  // counter only needs to reach TIMEOUT-1
  localparam int unsigned TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   req_edge;
  logic [TO_W-1:0]        to_cnt;
  logic [ADR_W-1:0]       next_adr;
  logic                   to_hit;

  assign req_edge = sync_q[SYNC_STAGES-1] ^ prev_q;
  assign to_hit   = (TIMEOUT != 0) && (to_cnt == TO_W'(TIMEOUT - 1));

  // Synchronise the request toggle and keep one cycle of history for edge detection
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q[0] <= la_req_tgl;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Command FSM: capture on request edge, run the bus cycle, then report completion
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state      <= S_IDLE;
      la_ack_tgl <= 1'b0;
      la_rdat    <= '0;
      la_err     <= 1'b0;
      la_busy    <= 1'b0;
      la_cnt     <= '0;
      wbm_cyc_o  <= 1'b0;
      wbm_stb_o  <= 1'b0;
      wbm_we_o   <= 1'b0;
      wbm_sel_o  <= '0;
      wbm_adr_o  <= '0;
      wbm_dat_o  <= '0;
      to_cnt     <= '0;
      next_adr   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_edge) begin
            wbm_we_o  <= la_we;
            wbm_sel_o <= la_sel;
            wbm_dat_o <= la_dat;
            wbm_adr_o <= la_adr_inc ? next_adr : la_adr;
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            la_busy   <= 1'b1;
            to_cnt    <= '0;
            state     <= S_BUS;
          end
        end
        S_BUS: begin
          // ack takes priority over a coincident timeout
          if (wbm_ack_i) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            if (!wbm_we_o) begin
              la_rdat <= wbm_dat_i;
            end
            la_err    <= 1'b0;
            next_adr  <= wbm_adr_o + ADR_W'(SEL_W);
            state     <= S_DONE;
          end else if (to_hit) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            la_err    <= 1'b1;
            state     <= S_DONE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        S_DONE: begin
          la_ack_tgl <= ~la_ack_tgl;
          la_cnt     <= la_cnt + 16'd1;
          la_busy    <= 1'b0;
          state      <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
